// File: rtl/seq_multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package seq_multdiv_pkg;
  localparam int WIDTH_DEF = 32;
  // Index of the final shift/add or quotient iteration; completion lands one edge later.
  localparam int ITER_LAST = WIDTH_DEF - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/seq_multdiv_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;

  assign shifted  = {rem, dvd_bit};
  assign q_bit    = (shifted >= {1'b0, divisor});
  // rem < divisor on entry, so a successful subtract always fits in WIDTH bits
  assign rem_next = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_multdiv_unit.sv
// Iterative signed multiply/divide: sign-magnitude core, one bit per cycle, fixed latency.
module seq_multdiv_unit
  import seq_multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, mcand, prod_s;
  logic [WIDTH-1:0]   mplier, quo, dvs, rem, rem_nx, quo_s, mag_a, mag_b;
  logic               neg, b_zero, div_ovf, start, last, q_bit, mul_exc;

  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = (cnt == CNT_END);
  // Negating MIN_NEG yields MIN_NEG, which read unsigned is the correct magnitude
  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign prod_s  = neg ? -acc : acc;
  assign quo_s   = neg ? -quo : quo;
  assign mul_exc = ~(&prod_s[2*WIDTH-1:WIDTH-1] | ~|prod_s[2*WIDTH-1:WIDTH-1]);

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (rem),
    .divisor (dvs),
    .dvd_bit (quo[WIDTH-1]),
    .rem_next(rem_nx),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nx = state;
    case (state)
      MUL, DIV: if (last) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (ctrl_MULT)     state_nx = MUL;
    else if (ctrl_DIV) state_nx = DIV;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      quo            <= '0;
      dvs            <= '0;
      rem            <= '0;
      neg            <= 1'b0;
      b_zero         <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        cnt     <= '0;
        acc     <= '0;
        mcand   <= {{WIDTH{1'b0}}, mag_a};
        mplier  <= mag_b;
        quo     <= mag_a;
        dvs     <= mag_b;
        rem     <= '0;
        neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        b_zero  <= (data_operandB == '0);
        div_ovf <= (data_operandA == MIN_NEG) && (&data_operandB);
      end else if (state == MUL || state == DIV) begin
        if (last) begin
          data_resultRDY <= 1'b1;
          if (state == MUL) begin
            data_result    <= prod_s[WIDTH-1:0];
            data_exception <= mul_exc;
          end else begin
            data_result    <= b_zero ? '0 : quo_s;
            data_exception <= b_zero | div_ovf;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (state == MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            rem <= rem_nx;
            quo <= {quo[WIDTH-2:0], q_bit};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_multdiv_unit.sv
// Self-checking bench: directed table, abort/reset sequences, randomized ops vs arithmetic model.
module tb_seq_multdiv_unit;
  import seq_multdiv_pkg::*;

  localparam int LAT = ITER_LAST + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int n_pass = 0, n_total = 0, rdy_count = 0;

  seq_multdiv_unit dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;
  always @(negedge clock) if (data_resultRDY) rdy_count++;

  typedef struct {
    bit          mul;
    logic [31:0] a, b, res;
    bit          exc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference behaviour from plain signed arithmetic.
  task automatic model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint p;
    int ia, ib;
    ia = a;
    ib = b;
    if (mul) begin
      p = longint'(ia) * longint'(ib);
      r = p[31:0];
      e = (p != longint'(int'(r)));
    end else if (b == 32'd0) begin
      r = '0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1;
    end else begin
      r = ia / ib; e = 1'b0;
    end
  endtask

  // Issue a one-cycle start and return the number of cycles until RDY (-1 if never).
  task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin lat = k; break; end
    end
  endtask

  task automatic run_chk(input string nm, input bit m, input bit d, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input bit ee);
    int lat;
    do_op(m, d, a, b, lat);
    chk({nm, "_lat"}, lat, LAT);
    chk({nm, "_res"}, data_result, er);
    chk({nm, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
    @(negedge clock);
    chk({nm, "_rdy_low"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 6))
      0: return 32'($urandom_range(0, 20)) - 32'd10;
      1: return 32'h8000_0000;
      2: return 32'd0;
      3: return 32'hFFFF_FFFF;
      4: return {{16{h[15]}}, h};
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl[12];

  initial begin
    int c0;
    int lat;
    logic [31:0] er, a, b;
    logic ee;
    bit m;

    tbl[0]  = '{1'b1, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
    tbl[1]  = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
    tbl[2]  = '{1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
    tbl[3]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    tbl[4]  = '{1'b0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    tbl[5]  = '{1'b0, 32'd5,          32'd0,         32'h0000_0000, 1'b1};
    tbl[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[7]  = '{1'b1, 32'd0,          32'hFFFF_FFFB, 32'h0000_0000, 1'b0};
    tbl[8]  = '{1'b1, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1};
    tbl[9]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[10] = '{1'b0, 32'hFFFF_FFF8,  32'hFFFF_FFFE, 32'd4,         1'b0};
    tbl[11] = '{1'b0, 32'd3,          32'd7,         32'd0,         1'b0};

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_res", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      run_chk($sformatf("tbl%0d", i), tbl[i].mul, !tbl[i].mul, tbl[i].a, tbl[i].b,
              tbl[i].res, tbl[i].exc);

    // Abort a multiply with a divide at cycle 10: only the divide completes
    c0 = rdy_count;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (8) @(negedge clock);
    do_op(1'b0, 1'b1, 32'd9, 32'd3, lat);
    chk("abort_lat", lat, LAT);
    chk("abort_res", data_result, 32'd3);
    repeat (40) @(negedge clock);
    chk("abort_rdy_cnt", rdy_count - c0, 32'd1);

    run_chk("both", 1'b1, 1'b1, 32'd6, 32'd2, 32'd12, 1'b0);

    // Reset in the middle of a multiply
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd5;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    chk("midrst_res", data_result, 32'd0);
    chk("midrst_exc", {31'd0, data_exception}, 32'd0);
    chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    c0 = rdy_count;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("midrst_no_rdy", rdy_count - c0, 32'd0);
    run_chk("post_rst", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk($sformatf("hold%0d", k), data_result, 32'd1);
    end

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = rnd_opnd();
      b = rnd_opnd();
      model(m, a, b, er, ee);
      run_chk($sformatf("rnd%0d_%s_%h_%h", i, m ? "mul" : "div", a, b), m, !m, a, b, er, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
